uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit scheduler sitting in front of the UART transmit unit. It takes bytes from two independent requesters over valid/ready, arbitrates between them round-robin, and buffers them in a small FIFO. It drives the transmit unit's send strobe, data and configuration one frame at a time, holding data and configuration stable for the whole frame. It also detects a transmit unit that fails to start.

## Interface
- FIFO_DEPTH, 4: buffered bytes; power of two, ≥2.
- START_TIMEOUT, 4096: clock cycles allowed between raising tx_send and seeing tx_active.

Ports:
- clock  in  1  system clock; single clock domain.
- reset_n  in  1  reset, synchronous and active-low.
- cfg_parity_type  in  2  requested parity type; sampled only at frame start.
- cfg_baud_rate  in  2  requested baud rate; sampled only at frame start.
- req0_valid / req1_valid  in  1  requester has a byte.
- req0_data / req1_data  in  8  requester byte.
- req0_ready / req1_ready  out  1  byte accepted this cycle when valid&ready.
- tx_send  out  1  send enable to the transmit unit.
- tx_data  out  8  byte to the transmit unit; stable from START entry to BUSY exit.
- tx_parity_type  out  2  latched parity type to the transmit unit.
- tx_baud_rate  out  2  latched baud rate to the transmit unit.
- tx_active  in  1  transmit unit active flag (baud-clock timed level).
- tx_done  in  1  transmit unit done flag (baud-clock timed level).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes buffered.
- busy  out  1  high when state ≠ IDLE or fifo_count ≠ 0.
- timeout_err  out  1  one-cycle pulse on start timeout.

## Operation
- Arbitration: a pointer `last` marks the requester served most recently. If one requester is valid, it gets the grant. If both are valid, the one ≠ last gets it. `last` updates only on an accepted transfer.
- readyN = grantN & ~full. Ready is computed from the registered count only: a pop in the same cycle does not free a slot. At most one push per cycle.
- tx_active and tx_done each pass through a 2-flop synchronizer (act_s, done_s) before use.
- FSM states:
  - IDLE:
    - tx_send = 0.
    - If FIFO is non-empty: pop the head into tx_data, latch cfg_* into tx_parity_type/tx_baud_rate, clear the timeout counter, and go to START.
  - START:
    - tx_send = 1.
    - act_s = 1 → go to BUSY; tx_send falls on that transition.
    - Counter reaches START_TIMEOUT-1 with act_s = 0 → pulse timeout_err, discard the byte, return to IDLE.
  - BUSY:
    - tx_send = 0.
    - act_s = 0 and done_s = 1 → go to IDLE.
- Push and pop in the same cycle are legal; the count is unchanged.
- The FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty; last = requester 1, so requester 0 wins first contention.
- Reset mid-frame: at the reset edge, tx_send drops, the FIFO and synchronizers clear, and no timeout_err is raised. The transmit unit shares reset_n.
- Latency:
  - Byte accepted at edge N → fifo_count increments after edge N.
  - IDLE pops at edge N+1 → tx_send is high in cycle N+1 onward (registered).
  - From an empty FIFO, the first tx_send rises 1 cycle after acceptance.
- Frame end to next tx_send: done seen at the synchronizer output → IDLE at the next edge → START one edge later if the FIFO is non-empty.
- cfg_* changes outside IDLE have no effect until the next IDLE→START transition.
- Full: ready = 0 for both requesters; valid held high is not lost.
- Empty in IDLE: stay in IDLE; tx_data holds its previous value.

## Structure
- Package uart_tx_sched_pkg:
  - state enum {IDLE, START, BUSY}.
  - Requester id type.
- Sub-module uart_tx_fifo:
  - Synchronous FIFO, FIFO_DEPTH×8.
  - Ports: push, push_data, pop, head_data, count, full, empty.
  - Same clock and synchronous reset.
- Arbiter, synchronizers, FSM and timeout counter live in the top level.

## Test plan
- Single byte: req0 sends 0xA5; a transmit-unit model raises active 5 cycles after send and done 200 cycles later → tx_data = 0xA5 through BUSY, tx_send high ≥ 3 cycles, one frame only.
- Contention: both requesters valid continuously with 0x11.. / 0x22.. → accepted order 0x11, 0x22, 0x12, 0x23, …, and frames go out in the same order.
- Full FIFO: push 4 bytes while the model stalls active → ready = 0 on the 5th, fifo_count = 4; after the first pop, the 5th byte is accepted the cycle after the count drops.
- Config latch: cfg_baud_rate changes 1→3 during BUSY → tx_baud_rate stays 1 until the next frame start, then becomes 3.
- Timeout: the model never raises active, START_TIMEOUT = 16 → timeout_err is a single pulse 16 cycles after tx_send rises, the byte is dropped, and the next byte starts normally.
- Reset mid-BUSY with 3 bytes queued → next cycle: tx_send = 0, fifo_count = 0, state IDLE, timeout_err = 0.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types for the UART transmit scheduler: frame FSM states and requester ids.
package uart_tx_sched_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the requester arbiter and the frame FSM; FIFO_DEPTH must be a power of two.
module uart_tx_fifo
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic [7:0]                  push_data,
  input  logic                        pop,
  output logic [7:0]                  head_data,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  byte_t         mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is left unreset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin arbitration of two byte requesters into a FIFO, feeding a UART transmit unit
// one frame at a time with a start-timeout watchdog.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned START_TIMEOUT = 4096
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [1:0]                  cfg_parity_type,
  input  logic [1:0]                  cfg_baud_rate,
  input  logic                        req0_valid,
  input  logic [7:0]                  req0_data,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [7:0]                  req1_data,
  output logic                        req1_ready,
  output logic                        tx_send,
  output logic [7:0]                  tx_data,
  output logic [1:0]                  tx_parity_type,
  output logic [1:0]                  tx_baud_rate,
  input  logic                        tx_active,
  input  logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned TW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

  state_t        state_q, state_d;
  req_id_t       last_q, last_d;
  logic          act_meta_q, act_s_q, done_meta_q, done_s_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [7:0]    tx_data_q, head_data;
  logic [1:0]    parity_q, baud_q;
  logic          timeout_q, timeout_d;
  logic          grant0, grant1, fifo_full, fifo_empty, push, pop, start_expired;
  logic [7:0]    push_data;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
  assign grant0     = req0_valid & (~req1_valid | (last_q == REQ1));
  assign grant1     = req1_valid & (~req0_valid | (last_q == REQ0));
  assign req0_ready = grant0 & ~fifo_full;
  assign req1_ready = grant1 & ~fifo_full;
  assign push       = req0_ready | req1_ready;
  assign push_data  = req0_ready ? req0_data : req1_data;
  assign last_d     = req0_ready ? REQ0 : (req1_ready ? REQ1 : last_q);

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign start_expired = (tmo_cnt_q == TW'(START_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (act_s_q) state_d = BUSY;
               else if (start_expired) state_d = IDLE;
      BUSY:    if (!act_s_q && done_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_send   = 1'b0;
    pop       = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE:    pop = ~fifo_empty;
      START: begin
        tx_send   = 1'b1;
        timeout_d = ~act_s_q & start_expired;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      act_meta_q  <= 1'b0;
      act_s_q     <= 1'b0;
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
      last_q      <= REQ1;
      tmo_cnt_q   <= '0;
      tx_data_q   <= '0;
      parity_q    <= '0;
      baud_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      act_meta_q  <= tx_active;
      act_s_q     <= act_meta_q;
      done_meta_q <= tx_done;
      done_s_q    <= done_meta_q;
      last_q      <= last_d;
      timeout_q   <= timeout_d;
      if (pop) begin
        tx_data_q <= head_data;
        parity_q  <= cfg_parity_type;
        baud_q    <= cfg_baud_rate;
        tmo_cnt_q <= '0;
      end else if (state_q == START) begin
        tmo_cnt_q <= tmo_cnt_q + TW'(1);
      end
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_parity_type = parity_q;
  assign tx_baud_rate   = baud_q;
  assign timeout_err    = timeout_q;
  assign busy           = (state_q != IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: byte sources, a transmit-unit model and a queue-based scoreboard
// that predicts handshakes, occupancy and frame contents from the arbitration and FIFO rules.
module tb_uart_tx_sched;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] cfg_parity_type = '0, cfg_baud_rate = '0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, tx_send, busy, timeout_err;
  logic [7:0] tx_data;
  logic [1:0] tx_parity_type, tx_baud_rate;
  logic       tx_active = 1'b0, tx_done = 1'b0;
  logic [2:0] fifo_count;

  uart_tx_sched #(.FIFO_DEPTH(DEPTH), .START_TIMEOUT(TMO)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cfg_parity_type (cfg_parity_type),
    .cfg_baud_rate   (cfg_baud_rate),
    .req0_valid      (req0_valid),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .tx_send         (tx_send),
    .tx_data         (tx_data),
    .tx_parity_type  (tx_parity_type),
    .tx_baud_rate    (tx_baud_rate),
    .tx_active       (tx_active),
    .tx_done         (tx_done),
    .fifo_count      (fifo_count),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte sources and transmit-unit model controls
  logic [7:0] src0[$], src1[$];
  bit         gap_en = 1'b0, cfg_rand = 1'b0, no_start = 1'b0, rand_model = 1'b0;
  int         act_dly = 5, busy_len = 20, phase = 0, mcnt = 0, frames_done = 0;

  // Scoreboard state
  logic [7:0] exp_q[$], acc_log[$];
  int         model_count = 0, send_cyc = 0, frames_started = 0, timeouts = 0;
  bit         model_last = 1'b1, push_prev = 1'b0, send_prev = 1'b0, rst_prev = 1'b0;
  bit         acc0 = 1'b0, acc1 = 1'b0, mon_rise, exp_r0, exp_r1;
  logic [7:0] cur_exp = '0;
  logic [1:0] cur_baud = '0, cur_par = '0, cfg_baud_prev = '0, cfg_par_prev = '0;

  always @(negedge clock) begin
    if (!rst_prev) begin
      check("rst_tx_send", 32'(tx_send), 0);
      check("rst_fifo_count", 32'(fifo_count), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_timeout", 32'(timeout_err), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_baud", 32'(tx_baud_rate), 0);
      check("rst_parity", 32'(tx_parity_type), 0);
      model_count = 0;
      model_last  = 1'b1;
      exp_q.delete();
      push_prev = 1'b0;
      send_prev = 1'b0;
    end else begin
      mon_rise    = tx_send && !send_prev;
      model_count = model_count + int'(push_prev) - int'(mon_rise);
      check("fifo_count", 32'(fifo_count), 32'(model_count));
      if (mon_rise) begin
        check("frame_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
        check("tx_data_start", 32'(tx_data), 32'(cur_exp));
        check("baud_start", 32'(tx_baud_rate), 32'(cfg_baud_prev));
        check("parity_start", 32'(tx_parity_type), 32'(cfg_par_prev));
        cur_baud = cfg_baud_prev;
        cur_par  = cfg_par_prev;
        frames_started++;
        send_cyc = 0;
      end else begin
        send_cyc++;
      end
      if (send_prev && !tx_send && !timeout_err) check("send_len_ge3", 32'(send_cyc >= 3), 1);
      if (timeout_err) begin
        check("timeout_latency", 32'(send_cyc), TMO);
        timeouts++;
      end
      if (tx_active) begin
        check("tx_data_busy", 32'(tx_data), 32'(cur_exp));
        check("baud_busy", 32'(tx_baud_rate), 32'(cur_baud));
        check("parity_busy", 32'(tx_parity_type), 32'(cur_par));
      end
      send_prev = tx_send;
    end
    cfg_baud_prev = cfg_baud_rate;
    cfg_par_prev  = cfg_parity_type;
    if (reset_n) begin
      exp_r0 = req0_valid && (!req1_valid || model_last) && (model_count < DEPTH);
      exp_r1 = req1_valid && (!req0_valid || !model_last) && (model_count < DEPTH);
      check("req0_ready", 32'(req0_ready), 32'(exp_r0));
      check("req1_ready", 32'(req1_ready), 32'(exp_r1));
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0) begin exp_q.push_back(req0_data); acc_log.push_back(req0_data); model_last = 1'b0; end
      if (acc1) begin exp_q.push_back(req1_data); acc_log.push_back(req1_data); model_last = 1'b1; end
      push_prev = acc0 || acc1;
    end else begin
      acc0 = 1'b0;
      acc1 = 1'b0;
      push_prev = 1'b0;
    end
    rst_prev = reset_n;
  end

  // Requester drivers: a presented byte stays valid until accepted
  initial forever begin
    @(posedge clock);
    #1;
    if (!reset_n) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end else begin
      if (acc0 && src0.size() > 0) void'(src0.pop_front());
      if (acc1 && src1.size() > 0) void'(src1.pop_front());
      if (!req0_valid || acc0) begin
        req0_valid = (src0.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
        if (req0_valid) req0_data = src0[0];
      end
      if (!req1_valid || acc1) begin
        req1_valid = (src1.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
        if (req1_valid) req1_data = src1[0];
      end
      if (cfg_rand) begin
        cfg_baud_rate   = 2'($urandom_range(0, 3));
        cfg_parity_type = 2'($urandom_range(0, 3));
      end
    end
  end

  // Transmit-unit model: active act_dly cycles after send, done after busy_len cycles of activity
  initial forever begin
    @(posedge clock);
    #1;
    if (!reset_n) begin
      tx_active = 1'b0;
      tx_done   = 1'b0;
      phase     = 0;
      mcnt      = 0;
    end else begin
      case (phase)
        0: if (tx_send && !no_start) begin
             if (rand_model) begin
               act_dly  = $urandom_range(1, 6);
               busy_len = $urandom_range(4, 25);
             end
             mcnt  = 0;
             phase = 1;
           end
        1: begin
             mcnt++;
             if (mcnt >= act_dly) begin tx_active = 1'b1; mcnt = 0; phase = 2; end
           end
        2: begin
             mcnt++;
             if (mcnt >= busy_len) begin
               tx_active = 1'b0;
               tx_done   = 1'b1;
               mcnt      = 0;
               phase     = 3;
               frames_done++;
             end
           end
        default: begin
             mcnt++;
             if (mcnt >= 4) begin tx_done = 1'b0; phase = 0; end
           end
      endcase
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0;
    src0.delete();
    src1.delete();
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int bud);
    bit ok = 1'b0;
    for (int w = 0; w < bud && !ok; w++) begin
      tick();
      ok = (src0.size() == 0) && (src1.size() == 0) && !req0_valid && !req1_valid &&
           (exp_q.size() == 0) && (phase == 0) && !tx_send;
    end
    check({tag, "_drained"}, 32'(ok), 1);
    repeat (6) tick();
    check({tag, "_idle_busy"}, 32'(busy), 0);
    check({tag, "_idle_count"}, 32'(fifo_count), 0);
  endtask

  int f0, d0, t0;
  bit ok;

  initial begin
    repeat (3) step();
    reset_n = 1'b1;

    // Single byte, long frame
    act_dly = 5; busy_len = 200;
    f0 = frames_started; d0 = frames_done;
    src0.push_back(8'hA5);
    drain("single", 500);
    check("single_frames", 32'(frames_started - f0), 1);
    check("single_done", 32'(frames_done - d0), 1);
    check("single_hold_data", 32'(tx_data), 32'hA5);

    // Contention from reset: requester 0 wins first, then strict alternation
    do_reset();
    act_dly = 3; busy_len = 10;
    acc_log.delete();
    for (int i = 0; i < 4; i++) begin
      src0.push_back(8'(8'h11 + i));
      src1.push_back(8'(8'h22 + i));
    end
    drain("contention", 600);
    check("contention_count", 32'(acc_log.size()), 8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++)
      check("contention_order", 32'(acc_log[i]), (i % 2 == 0) ? 32'(8'h11 + i / 2) : 32'(8'h22 + i / 2));

    // Config latched only at frame start
    step();
    cfg_baud_rate = 2'd1; cfg_parity_type = 2'd2;
    act_dly = 5; busy_len = 40;
    f0 = frames_started;
    src0.push_back(8'h61); src0.push_back(8'h62);
    ok = 1'b0;
    for (int w = 0; w < 60 && !ok; w++) begin tick(); ok = tx_active; end
    check("cfg_wait_active", 32'(ok), 1);
    step();
    cfg_baud_rate = 2'd3;
    repeat (5) tick();
    check("cfg_hold_baud", 32'(tx_baud_rate), 1);
    ok = 1'b0;
    for (int w = 0; w < 200 && !ok; w++) begin tick(); ok = (frames_started == f0 + 2); end
    check("cfg_wait_second", 32'(ok), 1);
    check("cfg_new_baud", 32'(tx_baud_rate), 3);
    check("cfg_parity", 32'(tx_parity_type), 2);
    drain("cfg", 300);

    // Full FIFO while the transmit unit is held busy
    act_dly = 5; busy_len = 120;
    src0.push_back(8'hB0);
    ok = 1'b0;
    for (int w = 0; w < 60 && !ok; w++) begin tick(); ok = tx_active; end
    check("full_wait_active", 32'(ok), 1);
    step();
    for (int i = 1; i <= 5; i++) src0.push_back(8'(8'hB0 + i));
    ok = 1'b0;
    for (int w = 0; w < 30 && !ok; w++) begin tick(); ok = (fifo_count == 3'd4); end
    check("full_wait_count", 32'(ok), 1);
    repeat (3) tick();
    check("full_count", 32'(fifo_count), 4);
    check("full_ready0", 32'(req0_ready), 0);
    check("full_ready1", 32'(req1_ready), 0);
    ok = 1'b0;
    for (int w = 0; w < 200 && !ok; w++) begin tick(); ok = (fifo_count != 3'd4); end
    check("full_wait_pop", 32'(ok), 1);
    check("full_pop_count", 32'(fifo_count), 3);
    check("full_pop_ready0", 32'(req0_ready), 1);
    tick();
    check("full_refill_count", 32'(fifo_count), 4);
    drain("full", 1500);

    // Start timeout: byte dropped, next byte goes out normally
    no_start = 1'b1;
    t0 = timeouts;
    src0.push_back(8'h5A);
    ok = 1'b0;
    for (int w = 0; w < 80 && !ok; w++) begin tick(); ok = (timeouts == t0 + 1); end
    check("timeout_wait", 32'(ok), 1);
    repeat (4) tick();
    check("timeout_single", 32'(timeouts - t0), 1);
    check("timeout_send_low", 32'(tx_send), 0);
    check("timeout_count", 32'(fifo_count), 0);
    check("timeout_busy", 32'(busy), 0);
    step();
    no_start = 1'b0; act_dly = 5; busy_len = 15;
    d0 = frames_done;
    src0.push_back(8'h3C);
    drain("after_timeout", 200);
    check("after_timeout_done", 32'(frames_done - d0), 1);
    check("after_timeout_no_more", 32'(timeouts - t0), 1);

    // Reset in BUSY with three bytes queued
    act_dly = 5; busy_len = 200;
    for (int i = 0; i < 4; i++) src0.push_back(8'(8'hD0 + i));
    ok = 1'b0;
    for (int w = 0; w < 60 && !ok; w++) begin tick(); ok = tx_active && (fifo_count == 3'd3); end
    check("rstmid_wait", 32'(ok), 1);
    step();
    reset_n = 1'b0;
    src0.delete();
    src1.delete();
    tick();
    tick();
    check("rstmid_send", 32'(tx_send), 0);
    check("rstmid_count", 32'(fifo_count), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_timeout", 32'(timeout_err), 0);
    step();
    reset_n = 1'b1;
    act_dly = 4; busy_len = 12;
    d0 = frames_done;
    src0.push_back(8'hE7);
    drain("after_reset", 200);
    check("after_reset_done", 32'(frames_done - d0), 1);

    // Randomized traffic, gaps, config and transmit-unit timing
    rand_model = 1'b1; gap_en = 1'b1; cfg_rand = 1'b1;
    for (int i = 0; i < 16; i++) begin
      src0.push_back(8'($urandom));
      src1.push_back(8'($urandom));
    end
    drain("random", 4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
